// File: rtl/ula_n_bits_sequential_pkg.sv
// rtl/ula_n_bits_sequential_pkg.sv - opcode, state and flag types shared by the sequential ULA
package ula_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_NOT = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } ula_op_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ula_state_t;

    typedef struct packed {
        logic cout;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } ula_flags_t;

endpackage

// File: rtl/ula_n_bits_sequential_if.sv
// rtl/ula_n_bits_sequential_if.sv - operand/result handshake bundle of the sequential ULA
interface ula_n_bits_sequential_if #(
    parameter int WIDTH = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       X;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] S_HI;
    logic             COUT;
    logic             ZERO;
    logic             NEG;
    logic             OVF;
    logic             ERR;

    modport slave (
        input  IN_VALID, X, A, B, CIN, OUT_READY,
        output IN_READY, OUT_VALID, S, S_HI, COUT, ZERO, NEG, OVF, ERR
    );

    modport master (
        output IN_VALID, X, A, B, CIN, OUT_READY,
        input  IN_READY, OUT_VALID, S, S_HI, COUT, ZERO, NEG, OVF, ERR
    );
endinterface

// File: rtl/ula_n_bits_sequential_mul.sv
// rtl/ula_n_bits_sequential_mul.sv - iterative shift-add unsigned multiplier, one step per cycle
module ula_mul_iterative #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic               busy_q,   busy_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] addend;

    // product is the accumulator after the current step, valid as the final result when done
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        product  = acc_q + addend;
        done     = busy_q && (cnt_q == CW'(WIDTH - 1));
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/ula_n_bits_sequential.sv
// rtl/ula_n_bits_sequential.sv - registered WIDTH-bit ULA with valid/ready and iterative MUL
module ula_n_bits_sequential
    import ula_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    ula_n_bits_sequential_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    ula_state_t         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   s_hi_q, s_hi_d;
    ula_flags_t         flags_q, flags_d;

    logic [WIDTH:0]     wide;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   res_lo;
    ula_flags_t         res_fl;
    ula_flags_t         mul_fl;
    logic               in_ready, accept, is_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    always_comb begin
        wide   = '0;
        res_lo = '0;
        res_fl = '0;
        shamt  = bus.B[SW-1:0];
        case (ula_op_t'(bus.X))
            OP_ADD: begin
                wide        = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.CIN};
                res_lo      = wide[WIDTH-1:0];
                res_fl.cout = wide[WIDTH];
                res_fl.ovf  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res_lo[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                wide        = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.CIN};
                res_lo      = wide[WIDTH-1:0];
                res_fl.cout = wide[WIDTH];
                res_fl.ovf  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res_lo[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: res_lo = bus.A & bus.B;
            OP_OR:  res_lo = bus.A | bus.B;
            OP_NOT: res_lo = ~bus.A;
            OP_XOR: res_lo = bus.A ^ bus.B;
            // the extra bit of wide catches the last bit shifted out; it stays 0 for amount 0
            OP_SHL: begin
                wide        = {1'b0, bus.A} << shamt;
                res_lo      = wide[WIDTH-1:0];
                res_fl.cout = wide[WIDTH];
            end
            OP_SHR: begin
                wide        = {bus.A, 1'b0} >> shamt;
                res_lo      = wide[WIDTH:1];
                res_fl.cout = wide[0];
            end
            default: res_fl.err = 1'b1;
        endcase
        res_fl.zero = (res_lo == '0);
        res_fl.neg  = res_lo[WIDTH-1];

        mul_fl      = '0;
        mul_fl.cout = |mul_product[2*WIDTH-1:WIDTH];
        mul_fl.zero = (mul_product == '0);
        mul_fl.neg  = mul_product[WIDTH-1];
    end

    always_comb begin
        in_ready    = RST_N && (state_q == IDLE) && (!out_valid_q || bus.OUT_READY);
        accept      = bus.IN_VALID && in_ready;
        is_mul      = (bus.X == 4'(OP_MUL)) && (MUL_EN != 0);
        mul_start   = 1'b0;
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.OUT_READY;
        s_d         = s_q;
        s_hi_d      = s_hi_q;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    mul_start = 1'b1;
                    state_d   = MUL_BUSY;
                end else if (accept) begin
                    s_d         = res_lo;
                    s_hi_d      = '0;
                    flags_d     = res_fl;
                    out_valid_d = 1'b1;
                end
            end
            MUL_BUSY: begin
                // the slot was free on entry, so the product loads without waiting on the sink
                if (mul_done) begin
                    s_d         = mul_product[WIDTH-1:0];
                    s_hi_d      = mul_product[2*WIDTH-1:WIDTH];
                    flags_d     = mul_fl;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            s_hi_q      <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            s_hi_q      <= s_hi_d;
            flags_q     <= flags_d;
        end
    end

    ula_mul_iterative #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (mul_start),
        .a       (bus.A),
        .b       (bus.B),
        .done    (mul_done),
        .product (mul_product)
    );

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.S         = s_q;
    assign bus.S_HI      = s_hi_q;
    assign bus.COUT      = flags_q.cout;
    assign bus.ZERO      = flags_q.zero;
    assign bus.NEG       = flags_q.neg;
    assign bus.OVF       = flags_q.ovf;
    assign bus.ERR       = flags_q.err;
endmodule

// File: tb/tb_ula_n_bits_sequential.sv
// tb/tb_ula_n_bits_sequential.sv - directed vector bench for the sequential ULA
module tb_ula_n_bits_sequential;
    import ula_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic [W-1:0] shi;
        logic [4:0]   fl;   // {cout, zero, neg, ovf, err}
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ula_n_bits_sequential_if #(.WIDTH(W)) bus    ();
    ula_n_bits_sequential_if #(.WIDTH(W)) bus_nm ();

    ula_n_bits_sequential #(.WIDTH(W), .MUL_EN(1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    ula_n_bits_sequential #(.WIDTH(W), .MUL_EN(0)) dut_nm (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_nm)
    );

    assign bus_nm.IN_VALID  = bus.IN_VALID;
    assign bus_nm.X         = bus.X;
    assign bus_nm.A         = bus.A;
    assign bus_nm.B         = bus.B;
    assign bus_nm.CIN       = bus.CIN;
    assign bus_nm.OUT_READY = bus.OUT_READY;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [7:0] s, input logic [4:0] fl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.s = s; v.shi = 8'h00; v.fl = fl;
        return v;
    endfunction

    function automatic logic [4:0] dut_flags();
        return {bus.COUT, bus.ZERO, bus.NEG, bus.OVF, bus.ERR};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.X = op; bus.A = a; bus.B = b; bus.CIN = cin; bus.IN_VALID = 1'b1;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        drive(v.op, v.a, v.b, v.cin);
        #1 check({tag, " in_ready"}, bus.IN_READY, 1);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        check({tag, " out_valid"}, bus.OUT_VALID, 1);
        check({tag, " s"}, bus.S, v.s);
        check({tag, " s_hi"}, bus.S_HI, v.shi);
        check({tag, " flags"}, dut_flags(), v.fl);
    endtask

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [4:0] fl, input string tag);
        int lat;
        logic busy_ok;
        drive(4'(OP_MUL), a, b, 1'b0);
        #1 check({tag, " in_ready"}, bus.IN_READY, 1);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        check({tag, " nomul err"}, {bus_nm.OUT_VALID, bus_nm.ERR, bus_nm.ZERO, bus_nm.S, bus_nm.S_HI}, {3'b111, 16'h0000});
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.OUT_VALID && lat < 20) begin
            if (bus.IN_READY) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " in_ready low while busy"}, busy_ok, 1);
        check({tag, " s"}, bus.S, lo);
        check({tag, " s_hi"}, bus.S_HI, hi);
        check({tag, " flags"}, dut_flags(), fl);
    endtask

    initial begin
        vec_t vecs[19];
        logic stale;

        vecs[0]  = mk(4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 5'b11000);
        vecs[1]  = mk(4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 5'b00110);
        vecs[2]  = mk(4'h1, 8'h00, 8'h01, 1'b0, 8'hFF, 5'b10100);
        vecs[3]  = mk(4'h6, 8'h81, 8'h01, 1'b0, 8'h02, 5'b10000);
        vecs[4]  = mk(4'h7, 8'h81, 8'h03, 1'b0, 8'h10, 5'b00000);
        vecs[5]  = mk(4'hF, 8'h00, 8'h00, 1'b0, 8'h00, 5'b01001);
        vecs[6]  = mk(4'h0, 8'h12, 8'h34, 1'b1, 8'h47, 5'b00000);
        vecs[7]  = mk(4'h1, 8'h50, 8'h20, 1'b1, 8'h2F, 5'b00000);
        vecs[8]  = mk(4'h1, 8'h80, 8'h01, 1'b0, 8'h7F, 5'b00010);
        vecs[9]  = mk(4'h2, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000);
        vecs[10] = mk(4'h3, 8'hF0, 8'h0C, 1'b0, 8'hFC, 5'b00100);
        vecs[11] = mk(4'h4, 8'h0F, 8'hFF, 1'b1, 8'hF0, 5'b00100);
        vecs[12] = mk(4'h5, 8'hAA, 8'hAA, 1'b0, 8'h00, 5'b01000);
        vecs[13] = mk(4'h6, 8'h01, 8'h08, 1'b0, 8'h01, 5'b00000);
        vecs[14] = mk(4'h1, 8'h05, 8'h05, 1'b1, 8'hFF, 5'b10100);
        vecs[15] = mk(4'h9, 8'h12, 8'h34, 1'b0, 8'h00, 5'b01001);
        vecs[16] = mk(4'h7, 8'h80, 8'h07, 1'b0, 8'h01, 5'b00000);
        vecs[17] = mk(4'h6, 8'h80, 8'h01, 1'b0, 8'h00, 5'b11000);
        vecs[18] = mk(4'h0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 5'b10100);

        bus.IN_VALID = 1'b0; bus.X = 4'h0; bus.A = '0; bus.B = '0; bus.CIN = 1'b0;
        bus.OUT_READY = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset out_valid", bus.OUT_VALID, 0);
        check("reset in_ready", bus.IN_READY, 0);
        check("reset s", {bus.S, bus.S_HI, dut_flags()}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        do_mul(8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b10000, "mul ff*ff");
        do_op(mk(4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 5'b00000), "add after mul");
        do_mul(8'h0D, 8'h0B, 8'h8F, 8'h00, 5'b00100, "mul 0d*0b");

        for (int i = 0; i < 4; i++) begin
            drive(4'h0, 8'h10, 8'(i), 1'b0);
            #1 check($sformatf("b2b%0d in_ready", i), bus.IN_READY, 1);
            if (i > 0) check($sformatf("b2b%0d s", i - 1), {bus.OUT_VALID, bus.S}, {1'b1, 8'h10 + 8'(i - 1)});
            @(negedge clk);
        end
        check("b2b3 s", {bus.OUT_VALID, bus.S}, {1'b1, 8'h13});
        drive(4'h0, 8'h10, 8'h04, 1'b0);
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d held", i), {bus.OUT_VALID, bus.S}, {1'b1, 8'h13});
            check($sformatf("stall%0d in_ready", i), bus.IN_READY, 0);
            @(negedge clk);
        end
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        check("stall op kept", {bus.OUT_VALID, bus.S}, {1'b1, 8'h14});

        drive(4'(OP_MUL), 8'h0F, 8'h0F, 1'b0);
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midmul reset outputs", {bus.OUT_VALID, bus.S, bus.S_HI, dut_flags()}, 0);
        check("midmul reset in_ready", bus.IN_READY, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post reset ready", {bus.IN_READY, bus.OUT_VALID}, 2'b10);
        stale = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (bus.OUT_VALID) stale = 1'b1;
            @(negedge clk);
        end
        check("no stale mul result", stale, 0);
        do_op(mk(4'h0, 8'h21, 8'h21, 1'b0, 8'h42, 5'b00000), "add after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
